// File: rtl/uart_tx_fifo_ctrl_p_if.sv
// Bus bundle between the DSP write port / UART serializer and the TX FIFO controller.
// master drives writes and serializer status; slave is the FIFO controller.
interface uart_tx_fifo_ctrl_p_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LVL_W      = DEPTH_LOG2 + 1
);
    logic              DSP_CEn;
    logic              DSP_WEn;
    logic [DATA_W-1:0] DSP_WDATA;
    logic              TxFIFO_En;
    logic              TxFIFO_Flush;
    logic [LVL_W-1:0]  TxTrigLvl;
    logic              TxOvfClr;
    logic              TxBusy;
    logic              TxDone;
    logic              TxDataReady;
    logic [DATA_W-1:0] TxData;
    logic              TxFIFO_Empty;
    logic              TxFIFO_Full;
    logic              TxFIFO_Trig;
    logic [LVL_W-1:0]  TxFIFO_Level;
    logic              TxFIFO_Ovf;

    modport master (
        output DSP_CEn, DSP_WEn, DSP_WDATA, TxFIFO_En, TxFIFO_Flush, TxTrigLvl,
               TxOvfClr, TxBusy, TxDone,
        input  TxDataReady, TxData, TxFIFO_Empty, TxFIFO_Full, TxFIFO_Trig,
               TxFIFO_Level, TxFIFO_Ovf
    );

    modport slave (
        input  DSP_CEn, DSP_WEn, DSP_WDATA, TxFIFO_En, TxFIFO_Flush, TxTrigLvl,
               TxOvfClr, TxBusy, TxDone,
        output TxDataReady, TxData, TxFIFO_Empty, TxFIFO_Full, TxFIFO_Trig,
               TxFIFO_Level, TxFIFO_Ovf
    );
endinterface

// File: rtl/uart_tx_fifo_ctrl_p.sv
// UART transmit FIFO controller: buffers DSP byte writes in a circular buffer and offers
// the head entry to the serializer through a ready/busy/done handshake.
module uart_tx_fifo_ctrl_p #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LVL_W      = DEPTH_LOG2 + 1
) (
    input  logic                   DSP_CLK,
    input  logic                   RESET,
    uart_tx_fifo_ctrl_p_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level, level_nxt, edep;
    logic              wr_prev, en_prev;
    logic              tx_ready, empty, full, ovf;
    logic [DATA_W-1:0] tx_data;
    logic              wr, push_req, flush, push, pop, ovf_set;

    // Strobe edge detect and flush sources (explicit pulse or a mode change)
    always_comb begin
        wr       = !bus.DSP_CEn && !bus.DSP_WEn;
        push_req = wr && !wr_prev;
        flush    = bus.TxFIFO_Flush || (bus.TxFIFO_En != en_prev);
        edep     = bus.TxFIFO_En ? LVL_W'(DEPTH) : LVL_W'(1);
    end

    // Serializer handshake FSM; a pop only happens on TxDone while sending
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && (level != '0) && !bus.TxBusy) state_nxt = READY;
            end
            READY: begin
                if (flush)           state_nxt = IDLE;
                else if (bus.TxBusy) state_nxt = SEND;
            end
            SEND: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (bus.TxDone) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle
    always_comb begin
        push      = push_req && !flush && ((level < edep) || pop);
        ovf_set   = push_req && !flush && !push;
        level_nxt = level;
        if (flush)              level_nxt = '0;
        else if (push && !pop)  level_nxt = level + LVL_W'(1);
        else if (pop && !push)  level_nxt = level - LVL_W'(1);
    end

    always_ff @(posedge DSP_CLK) begin
        if (push) mem[wr_ptr] <= bus.DSP_WDATA;
    end

    always_ff @(posedge DSP_CLK) begin
        if (RESET) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_prev  <= 1'b1;
            en_prev  <= bus.TxFIFO_En;
            tx_ready <= 1'b0;
            tx_data  <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_prev <= wr;
            en_prev <= bus.TxFIFO_En;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level    <= level_nxt;
            empty    <= (level_nxt == '0);
            full     <= (level_nxt == edep);
            tx_ready <= (state_nxt == READY);
            // Head is latched on entry to READY and held through SEND
            if (state_nxt == READY) tx_data <= mem[rd_ptr];
            if (ovf_set)           ovf <= 1'b1;
            else if (bus.TxOvfClr) ovf <= 1'b0;
        end
    end

    assign bus.TxDataReady  = tx_ready;
    assign bus.TxData       = tx_data;
    assign bus.TxFIFO_Empty = empty;
    assign bus.TxFIFO_Full  = full;
    assign bus.TxFIFO_Level = level;
    assign bus.TxFIFO_Ovf   = ovf;
    assign bus.TxFIFO_Trig  = (level <= bus.TxTrigLvl);
endmodule
